// File: rtl/vga_fb_writer.sv
// vga_fb_writer
//   Write-side engine for the 1-bit VGA frame buffer (160x120 logical pixels).
//   It takes draw commands over a valid/ready handshake. The commands are pixel,
//   fill rectangle and full-screen clear. Each command becomes one buffer write
//   per clock, in raster order (X inner loop, Y outer loop).
//   The buffer address map is {Y[6:0], X[7:0]}.
//
// Ports
//   CLK, RESET            clock; synchronous active-high reset
//   CMD_VALID/CMD_READY   command handshake
//   CMD_OP                00 pixel, 01 fill rect, 10 clear, 11 reserved
//   CMD_X0/Y0, X1/Y1      start corner / inclusive end corner (end used by fill)
//   CMD_COLOUR            value to write
//   BUF_WE/ADDR/DATA      frame buffer write port
//   BUSY                  command executing (inverse of CMD_READY)
//   DONE                  one-cycle pulse when a command completes
//
// state  | meaning
// IDLE   | waiting for a command, CMD_READY=1
// DRAW   | one buffer write per cycle, BUF_WE=1
// FINISH | DONE pulse; also accepts the next command
module vga_fb_writer #(
  parameter int H_PIXELS = 160,
  parameter int V_PIXELS = 120
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic [1:0]  CMD_OP,
  input  logic [7:0]  CMD_X0,
  input  logic [6:0]  CMD_Y0,
  input  logic [7:0]  CMD_X1,
  input  logic [6:0]  CMD_Y1,
  input  logic        CMD_COLOUR,
  output logic        BUF_WE,
  output logic [14:0] BUF_ADDR,
  output logic        BUF_DATA,
  output logic        BUSY,
  output logic        DONE
);

  localparam logic [7:0] X_MAX = 8'(H_PIXELS - 1);
  localparam logic [6:0] Y_MAX = 7'(V_PIXELS - 1);

  typedef enum logic [1:0] {IDLE, DRAW, FINISH} state_t;

  state_t      state_q, state_d;
  logic [7:0]  x_q, x_d, x0_q, x0_d, x1_q, x1_d;
  logic [6:0]  y_q, y_d, y1_q, y1_d;
  logic        colour_q, colour_d;
  logic        we_q, we_d, data_q, data_d, ready_q, ready_d, busy_q, busy_d, done_q, done_d;
  logic [14:0] addr_q, addr_d;

  // This block turns the incoming command into a clipped rectangle.
  // A pixel command is a 1x1 rectangle. dec_any is low when there is nothing to write.
  logic [7:0] dec_x0, dec_x1;
  logic [6:0] dec_y0, dec_y1;
  logic       dec_any;

  always_comb begin
    dec_x0  = CMD_X0;
    dec_y0  = CMD_Y0;
    dec_x1  = CMD_X0;
    dec_y1  = CMD_Y0;
    dec_any = 1'b0;
    case (CMD_OP)
      2'b00: dec_any = (CMD_X0 <= X_MAX) && (CMD_Y0 <= Y_MAX);
      2'b01: begin
        dec_x1  = (CMD_X1 > X_MAX) ? X_MAX : CMD_X1;
        dec_y1  = (CMD_Y1 > Y_MAX) ? Y_MAX : CMD_Y1;
        dec_any = (CMD_X0 <= X_MAX) && (CMD_Y0 <= Y_MAX) &&
                  (dec_x1 >= CMD_X0) && (dec_y1 >= CMD_Y0);
      end
      2'b10: begin
        dec_x0  = 8'd0;
        dec_y0  = 7'd0;
        dec_x1  = X_MAX;
        dec_y1  = Y_MAX;
        dec_any = 1'b1;
      end
      default: dec_any = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    x0_d     = x0_q;
    x1_d     = x1_q;
    y1_d     = y1_q;
    colour_d = colour_q;
    addr_d   = addr_q;
    we_d     = 1'b0;
    data_d   = 1'b0;
    done_d   = 1'b0;
    ready_d  = ready_q;
    case (state_q)
      IDLE, FINISH: begin
        ready_d = 1'b1;
        state_d = IDLE;
        if (CMD_VALID && ready_q) begin
          x0_d     = dec_x0;
          x1_d     = dec_x1;
          y1_d     = dec_y1;
          colour_d = CMD_COLOUR;
          if (dec_any) begin
            state_d = DRAW;
            x_d     = dec_x0;
            y_d     = dec_y0;
            we_d    = 1'b1;
            data_d  = CMD_COLOUR;
            addr_d  = {dec_y0, dec_x0};
            ready_d = 1'b0;
          end else begin
            state_d = FINISH;
            done_d  = 1'b1;
          end
        end
      end
      DRAW: begin
        // x_q/y_q hold the coordinate that is on BUF_ADDR in this cycle.
        if (x_q == x1_q && y_q == y1_q) begin
          state_d = FINISH;
          done_d  = 1'b1;
          ready_d = 1'b1;
        end else begin
          if (x_q == x1_q) begin
            x_d = x0_q;
            y_d = y_q + 7'd1;
          end else begin
            x_d = x_q + 8'd1;
          end
          we_d   = 1'b1;
          data_d = colour_q;
          addr_d = {y_d, x_d};
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
    busy_d = ~ready_d;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      x0_q     <= '0;
      x1_q     <= '0;
      y1_q     <= '0;
      colour_q <= 1'b0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      data_q   <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      x0_q     <= x0_d;
      x1_q     <= x1_d;
      y1_q     <= y1_d;
      colour_q <= colour_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      data_q   <= data_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign CMD_READY = ready_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign BUF_WE    = we_q;
  assign BUF_ADDR  = addr_q;
  assign BUF_DATA  = data_q;

endmodule

// File: tb/tb_vga_fb_writer.sv
module tb_vga_fb_writer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic [1:0]  CMD_OP;
  logic [7:0]  CMD_X0, CMD_X1;
  logic [6:0]  CMD_Y0, CMD_Y1;
  logic        CMD_COLOUR;
  logic        BUF_WE;
  logic [14:0] BUF_ADDR;
  logic        BUF_DATA;
  logic        BUSY;
  logic        DONE;

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];

  vga_fb_writer dut (
    .CLK(CLK), .RESET(RESET), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_OP(CMD_OP), .CMD_X0(CMD_X0), .CMD_Y0(CMD_Y0), .CMD_X1(CMD_X1),
    .CMD_Y1(CMD_Y1), .CMD_COLOUR(CMD_COLOUR), .BUF_WE(BUF_WE),
    .BUF_ADDR(BUF_ADDR), .BUF_DATA(BUF_DATA), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: the list of addresses (y*256 + x) that the command must write, in raster order.
  task automatic model(input int op, input int x0, input int y0, input int x1, input int y1);
    int xe, ye;
    exp_q.delete();
    case (op)
      0: if (x0 < 160 && y0 < 120) exp_q.push_back(y0 * 256 + x0);
      1: begin
        xe = (x1 > 159) ? 159 : x1;
        ye = (y1 > 119) ? 119 : y1;
        if (x0 < 160 && y0 < 120 && xe >= x0 && ye >= y0)
          for (int y = y0; y <= ye; y++)
            for (int x = x0; x <= xe; x++)
              exp_q.push_back(y * 256 + x);
      end
      2: for (int y = 0; y < 120; y++)
           for (int x = 0; x < 160; x++)
             exp_q.push_back(y * 256 + x);
      default: ;
    endcase
  endtask

  task automatic scramble();
    CMD_OP     = 2'($urandom);
    CMD_X0     = 8'($urandom);
    CMD_Y0     = 7'($urandom);
    CMD_X1     = 8'($urandom);
    CMD_Y1     = 7'($urandom);
    CMD_COLOUR = 1'($urandom);
  endtask

  // This task is entered at a negedge while the DUT is ready. It returns at the negedge
  // of the DONE cycle, or at the negedge after an abort.
  // If abort_after > 0, RESET is asserted after that many writes.
  task automatic run_cmd(input int op, input int x0, input int y0, input int x1, input int y1,
                         input logic col, input int abort_after);
    model(op, x0, y0, x1, y1);
    chk("ready_before_cmd", CMD_READY, 1);
    CMD_VALID  = 1'b1;
    CMD_OP     = 2'(op);
    CMD_X0     = 8'(x0);
    CMD_Y0     = 7'(y0);
    CMD_X1     = 8'(x1);
    CMD_Y1     = 7'(y1);
    CMD_COLOUR = col;
    @(negedge CLK);
    CMD_VALID = 1'b0;
    scramble();
    for (int i = 0; i < exp_q.size(); i++) begin
      chk("we", BUF_WE, 1);
      chk("addr", BUF_ADDR, exp_q[i]);
      chk("data", BUF_DATA, col);
      chk("ready_busy", CMD_READY, 0);
      chk("busy", BUSY, 1);
      chk("done_early", DONE, 0);
      if (abort_after == i + 1) begin
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        chk("abort_we", BUF_WE, 0);
        chk("abort_done", DONE, 0);
        chk("abort_ready", CMD_READY, 1);
        chk("abort_busy", BUSY, 0);
        chk("abort_addr", BUF_ADDR, 0);
        @(negedge CLK);
        chk("abort_we2", BUF_WE, 0);
        chk("abort_done2", DONE, 0);
        return;
      end
      CMD_VALID = 1'($urandom);
      @(negedge CLK);
      CMD_VALID = 1'b0;
    end
    chk("end_we", BUF_WE, 0);
    chk("end_done", DONE, 1);
    chk("end_ready", CMD_READY, 1);
    chk("end_busy", BUSY, 0);
    chk("end_data", BUF_DATA, 0);
  endtask

  initial begin
    RESET     = 1'b1;
    CMD_VALID = 1'b0;
    scramble();
    repeat (2) @(negedge CLK);
    chk("rst_we", BUF_WE, 0);
    chk("rst_ready", CMD_READY, 1);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_addr", BUF_ADDR, 0);
    chk("rst_data", BUF_DATA, 0);
    RESET = 1'b0;
    @(negedge CLK);

    run_cmd(0, 5, 3, 0, 0, 1'b1, 0);
    chk("pixel_addr_model", exp_q[0], 32'h0305);
    run_cmd(1, 2, 1, 4, 2, 1'b0, 0);
    chk("fill_count", exp_q.size(), 6);
    @(negedge CLK);
    chk("idle_done", DONE, 0);
    run_cmd(2, 0, 0, 0, 0, 1'b1, 0);
    chk("clear_last_model", exp_q[exp_q.size()-1], 32'h779F);
    run_cmd(1, 150, 118, 200, 127, 1'b1, 0);
    chk("clip_count", exp_q.size(), 20);
    run_cmd(1, 10, 5, 9, 20, 1'b1, 0);
    run_cmd(3, 1, 1, 5, 5, 1'b1, 0);
    run_cmd(0, 160, 0, 0, 0, 1'b1, 0);
    run_cmd(0, 0, 120, 0, 0, 1'b1, 0);
    run_cmd(1, 159, 119, 255, 127, 1'b0, 0);
    run_cmd(2, 0, 0, 0, 0, 1'b1, 100);
    run_cmd(0, 7, 9, 0, 0, 1'b1, 0);

    for (int n = 0; n < 80; n++) begin
      int op, x0, y0, x1, y1;
      op = $urandom_range(0, 3);
      if (op == 2) op = 1;
      x0 = $urandom_range(0, 175);
      y0 = $urandom_range(0, 127);
      x1 = x0 + $urandom_range(0, 14) - 3;
      y1 = y0 + $urandom_range(0, 6) - 2;
      if (x1 < 0) x1 = 0;
      if (x1 > 255) x1 = 255;
      if (y1 < 0) y1 = 0;
      if (y1 > 127) y1 = 127;
      if ($urandom_range(0, 1) == 1) begin
        int gap;
        gap = $urandom_range(1, 3);
        for (int g = 0; g < gap; g++) begin
          @(negedge CLK);
          chk("gap_we", BUF_WE, 0);
          chk("gap_done", DONE, 0);
        end
      end
      run_cmd(op, x0, y0, x1, y1, 1'($urandom), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
